// File: rtl/regfile_mp_sb.sv
// Multi-port register file with a per-register busy scoreboard.
// NRD combinational read ports and NWR write ports. Same-cycle write data can
// optionally be forwarded to the reads. Busy bits mark destinations that issue
// has reserved and writeback has not yet written.
module regfile_mp_sb #(
  parameter int AWIDTH   = 5,
  parameter int DWIDTH   = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD*AWIDTH-1:0]   raddr,
  output logic [NRD*DWIDTH-1:0]   rdata,
  output logic [NRD-1:0]          rbusy,
  input  logic [NWR-1:0]          wen,
  input  logic [NWR*AWIDTH-1:0]   waddr,
  input  logic [NWR*DWIDTH-1:0]   wdata,
  input  logic                    rsv_en,
  input  logic [AWIDTH-1:0]       rsv_addr,
  output logic                    rsv_ok,
  output logic                    wr_conflict
);

  localparam int NREG = 1 << AWIDTH;
  localparam logic BYPASS_EN = (BYPASS != 32'sd0);
  localparam logic ZERO_EN   = (ZERO_REG != 32'sd0);

  // Architectural state
  logic [DWIDTH-1:0] regs_r [NREG];
  logic [NREG-1:0]   busy_r;
  logic              wr_conflict_r;

  // Unpacked views of the flattened port buses
  logic [AWIDTH-1:0] rd_addr_s [NRD];
  logic [AWIDTH-1:0] wr_addr_s [NWR];
  logic [DWIDTH-1:0] wr_data_s [NWR];
  logic [DWIDTH-1:0] rd_data_s [NRD];
  logic [NRD-1:0]    rd_busy_s;
  logic [NWR-1:0]    wr_live_s;

  logic              conflict_s;
  logic              rsv_hit_s;
  logic              rsv_zero_s;
  logic              rsv_ok_s;

  genvar gi;

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      assign rd_addr_s[gi] = raddr[gi*AWIDTH +: AWIDTH];
      assign rdata[gi*DWIDTH +: DWIDTH] = rd_data_s[gi];
    end
    for (gi = 0; gi < NWR; gi++) begin : g_wr
      assign wr_addr_s[gi] = waddr[gi*AWIDTH +: AWIDTH];
      assign wr_data_s[gi] = wdata[gi*DWIDTH +: DWIDTH];
      // A write to the hardwired zero register is dropped entirely
      assign wr_live_s[gi] = wen[gi] &&
                             !(ZERO_EN && (wr_addr_s[gi] == {AWIDTH{1'b0}}));
    end
  endgenerate

  assign rbusy       = rd_busy_s;
  assign rsv_ok      = rsv_ok_s;
  assign wr_conflict = wr_conflict_r;

  // Read ports: stored value, then forwarded write data (highest port last), then zero register
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_data_s[i] = regs_r[rd_addr_s[i]];
      rd_busy_s[i] = busy_r[rd_addr_s[i]];
      if (BYPASS_EN) begin
        for (int j = 0; j < NWR; j++) begin
          if (wen[j] && (wr_addr_s[j] == rd_addr_s[i])) begin
            rd_data_s[i] = wr_data_s[j];
            rd_busy_s[i] = 1'b0;
          end else begin
            // lower-priority source stays selected
          end
        end
      end else begin
        // reads see only the stored value
      end
      if (ZERO_EN && (rd_addr_s[i] == {AWIDTH{1'b0}})) begin
        rd_data_s[i] = {DWIDTH{1'b0}};
        rd_busy_s[i] = 1'b0;
      end else begin
        // non-zero register keeps the value chosen above
      end
    end
  end

  // Detect two or more live write ports aimed at the same register
  always_comb begin
    conflict_s = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (wr_live_s[i] && wr_live_s[j] && (wr_addr_s[i] == wr_addr_s[j])) begin
          conflict_s = 1'b1;
        end else begin
          // this pair does not collide
        end
      end
    end
  end

  // Reservation acceptance: free register, or one being written back this cycle
  always_comb begin
    rsv_hit_s = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      if (wen[j] && (wr_addr_s[j] == rsv_addr)) begin
        rsv_hit_s = 1'b1;
      end else begin
        // this port does not free the requested register
      end
    end
    rsv_zero_s = ZERO_EN && (rsv_addr == {AWIDTH{1'b0}});
    if (rsv_en) begin
      rsv_ok_s = rsv_zero_s || !busy_r[rsv_addr] || rsv_hit_s;
    end else begin
      rsv_ok_s = 1'b0;
    end
  end

  // Register data: ascending port order so the highest-index writer wins a collision
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_r[r] <= {DWIDTH{1'b0}};
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_live_s[j]) begin
          regs_r[wr_addr_s[j]] <= wr_data_s[j];
        end
      end
    end
  end

  // Busy bits: writeback clears, an accepted reservation sets and overrides the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= {NREG{1'b0}};
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_live_s[j]) begin
          busy_r[wr_addr_s[j]] <= 1'b0;
        end
      end
      if (rsv_ok_s && !rsv_zero_s) begin
        busy_r[rsv_addr] <= 1'b1;
      end
    end
  end

  // One-cycle conflict pulse for each cycle that had colliding writes
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_conflict_r <= 1'b0;
    end else begin
      wr_conflict_r <= conflict_s;
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb with a queue-based scoreboard.
// Stimulus pushes expected observations tagged with the cycle they belong to;
// a monitor on the falling edge pops and compares them.
module tb_regfile_mp_sb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NW = 2;

  localparam int K_RDATA = 0;
  localparam int K_RBUSY = 1;
  localparam int K_RSVOK = 2;
  localparam int K_CONF  = 3;

  typedef struct {
    int          cyc;
    int          kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic [NR-1:0]     rbusy;
  logic [NW-1:0]     wen;
  logic [NW*AW-1:0]  waddr;
  logic [NW*DW-1:0]  wdata;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic              rsv_ok;
  logic              wr_conflict;

  exp_t exp_q [$];
  int   cyc_cnt;
  int   checks;
  int   errors;

  regfile_mp_sb #(
    .AWIDTH(AW), .DWIDTH(DW), .NRD(NR), .NWR(NW), .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .rsv_ok(rsv_ok), .wr_conflict(wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic string kname(input int k);
    case (k)
      K_RDATA: return "rdata";
      K_RBUSY: return "rbusy";
      K_RSVOK: return "rsv_ok";
      K_CONF:  return "wr_conflict";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
      e = exp_q.pop_front();
      checks = checks + 1;
      case (e.kind)
        K_RDATA: act = rdata[e.idx*DW +: DW];
        K_RBUSY: act = {31'd0, rbusy[e.idx]};
        K_RSVOK: act = {31'd0, rsv_ok};
        K_CONF:  act = {31'd0, wr_conflict};
        default: act = 32'hxxxx_xxxx;
      endcase
      if (e.cyc < cyc_cnt) begin
        errors = errors + 1;
        $display("FAIL %s[%0d] cyc=%0d not sampled in time (now %0d)",
                 kname(e.kind), e.idx, e.cyc, cyc_cnt);
      end else if (act !== e.val) begin
        errors = errors + 1;
        $display("FAIL %s[%0d] cyc=%0d got=%h exp=%h",
                 kname(e.kind), e.idx, e.cyc, act, e.val);
      end
    end
  end

  task automatic expect_val(input int kind, input int idx, input logic [31:0] val);
    exp_t e;
    e.cyc  = cyc_cnt;
    e.kind = kind;
    e.idx  = idx;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Advance one cycle and return the control inputs to idle
  task automatic cycle();
    @(posedge clk);
    #1;
    rst    = 1'b0;
    wen    = '0;
    rsv_en = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wen[p]            = 1'b1;
    waddr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
  endtask

  task automatic set_rsv(input logic [AW-1:0] a);
    rsv_en   = 1'b1;
    rsv_addr = a;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    raddr    = '0;
    wen      = '0;
    waddr    = '0;
    wdata    = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    repeat (2) @(posedge clk);

    // 1: after reset every register reads 0, not busy, no conflict
    for (int a = 0; a < (1 << AW); a++) begin
      cycle();
      set_rd(0, a[AW-1:0]);
      set_rd(1, a[AW-1:0]);
      expect_val(K_RDATA, 0, 32'h0);
      expect_val(K_RDATA, 1, 32'h0);
      expect_val(K_RBUSY, 0, 32'h0);
      expect_val(K_RBUSY, 1, 32'h0);
      expect_val(K_CONF,  0, 32'h0);
    end

    // 2: forwarding of same-cycle write, then stored value
    cycle();
    set_wr(0, 5'd3, 32'hDEAD_BEEF);
    set_rd(0, 5'd3);
    set_rd(1, 5'd4);
    expect_val(K_RDATA, 0, 32'hDEAD_BEEF);
    expect_val(K_RBUSY, 0, 32'h0);
    expect_val(K_RDATA, 1, 32'h0);
    cycle();
    expect_val(K_RDATA, 0, 32'hDEAD_BEEF);

    // 3: colliding writes, highest port wins, one-cycle conflict pulse
    cycle();
    set_wr(0, 5'd7, 32'h11);
    set_wr(1, 5'd7, 32'h22);
    set_rd(0, 5'd7);
    expect_val(K_RDATA, 0, 32'h22);
    expect_val(K_CONF,  0, 32'h0);
    cycle();
    set_rd(0, 5'd7);
    expect_val(K_RDATA, 0, 32'h22);
    expect_val(K_CONF,  0, 32'h1);
    // collision on reg0 is not a conflict; distinct addresses are not either
    cycle();
    set_wr(0, 5'd0, 32'h55);
    set_wr(1, 5'd0, 32'h66);
    set_rd(1, 5'd0);
    expect_val(K_RDATA, 1, 32'h0);
    expect_val(K_CONF,  0, 32'h0);
    cycle();
    set_wr(0, 5'd1, 32'hA);
    set_wr(1, 5'd2, 32'hB);
    set_rd(1, 5'd0);
    expect_val(K_RDATA, 1, 32'h0);
    expect_val(K_CONF,  0, 32'h0);
    cycle();
    set_rd(0, 5'd1);
    set_rd(1, 5'd2);
    expect_val(K_RDATA, 0, 32'hA);
    expect_val(K_RDATA, 1, 32'hB);
    expect_val(K_CONF,  0, 32'h0);

    // 4: reserve, refused re-reserve, writeback clears busy
    cycle();
    set_rsv(5'd5);
    set_rd(0, 5'd5);
    expect_val(K_RSVOK, 0, 32'h1);
    expect_val(K_RBUSY, 0, 32'h0);
    cycle();
    set_rsv(5'd5);
    set_rd(0, 5'd5);
    expect_val(K_RSVOK, 0, 32'h0);
    expect_val(K_RBUSY, 0, 32'h1);
    cycle();
    set_wr(0, 5'd5, 32'h9);
    set_rsv(5'd0);
    set_rd(0, 5'd5);
    set_rd(1, 5'd0);
    expect_val(K_RSVOK, 0, 32'h1);
    expect_val(K_RDATA, 0, 32'h9);
    expect_val(K_RBUSY, 0, 32'h0);
    cycle();
    set_rd(0, 5'd5);
    set_rd(1, 5'd0);
    expect_val(K_RDATA, 0, 32'h9);
    expect_val(K_RBUSY, 0, 32'h0);
    expect_val(K_RBUSY, 1, 32'h0);

    // 5: write and re-reserve in the same cycle keeps the register busy
    cycle();
    set_rsv(5'd5);
    expect_val(K_RSVOK, 0, 32'h1);
    cycle();
    set_wr(1, 5'd5, 32'h77);
    set_rsv(5'd5);
    expect_val(K_RSVOK, 0, 32'h1);
    cycle();
    set_rd(0, 5'd5);
    expect_val(K_RDATA, 0, 32'h77);
    expect_val(K_RBUSY, 0, 32'h1);
    cycle();
    set_wr(0, 5'd5, 32'h78);
    cycle();
    set_rd(0, 5'd5);
    expect_val(K_RDATA, 0, 32'h78);
    expect_val(K_RBUSY, 0, 32'h0);

    // 6: reset discards the writes and reservation of its cycle
    cycle();
    set_rsv(5'd9);
    expect_val(K_RSVOK, 0, 32'h1);
    cycle();
    rst = 1'b1;
    set_wr(0, 5'd7, 32'h33);
    set_wr(1, 5'd7, 32'h44);
    set_rsv(5'd10);
    set_rd(1, 5'd9);
    expect_val(K_RBUSY, 1, 32'h1);
    cycle();
    set_rd(0, 5'd7);
    set_rd(1, 5'd9);
    expect_val(K_RDATA, 0, 32'h0);
    expect_val(K_RBUSY, 1, 32'h0);
    expect_val(K_CONF,  0, 32'h0);
    cycle();
    set_rd(0, 5'd10);
    set_rd(1, 5'd3);
    expect_val(K_RBUSY, 0, 32'h0);
    expect_val(K_RDATA, 1, 32'h0);

    cycle();
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s[%0d] cyc=%0d never compared", kname(e.kind), e.idx, e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
